// File: rtl/br32_pkg.sv
// Shared LSU types: FSM state encoding, memory access size codes and the
// alignment rule used to accept or fault an access.
package br32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size code 3 is reserved and always treated as misaligned.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = ~off[0];
      SZ_W:    is_aligned = (off == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: byte enables for an outgoing access and extraction plus
// sign/zero extension of returned load data.
module lsu_lane
  import br32_pkg::*;
(
  input  logic [1:0]  be_sz_i,
  input  logic [1:0]  be_off_i,
  output logic [3:0]  be_o,
  input  logic [1:0]  ld_sz_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_sx_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o = 4'b1111;
    case (be_sz_i)
      SZ_B:    be_o = 4'b0001 << be_off_i;
      SZ_H:    be_o = 4'b0011 << {be_off_i[1], 1'b0};
      default: be_o = 4'b1111;
    endcase
  end

  assign shifted = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = shifted;
    case (ld_sz_i)
      SZ_B:    ld_data_o = {{24{ld_sx_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data_o = {{16{ld_sx_i & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus master: accepts one access from EX, runs a single
// request/response on the data bus and stalls the pipeline meanwhile.
module lsu_bus
  import br32_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic        ex_mem_r,
  input  logic        ex_mem_w,
  input  logic [1:0]  ex_mem_sz,
  input  logic        ex_mem_sx,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [4:0]  ld_rd,
  output logic [31:0] ld_data,
  output logic        exn_misalign,
  output logic [31:0] exn_addr
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q, sx_q;
  logic [1:0]  sz_q;
  logic [4:0]  rd_q;
  logic        ld_valid_q, exn_q;
  logic [4:0]  ld_rd_q;
  logic [31:0] ld_data_q, exn_addr_q;

  logic        access, aligned, accept, misalign, resp_take;
  logic [3:0]  be_new;
  logic [31:0] ld_ext;

  assign access    = ex_valid && (ex_mem_r || ex_mem_w);
  assign aligned   = is_aligned(ex_mem_sz, ex_addr[1:0]);
  assign accept    = (state_q == IDLE) && access && aligned;
  assign misalign  = (state_q == IDLE) && access && !aligned;
  assign resp_take = (state_q == WAIT) && resp_valid;

  lsu_lane u_lane (
    .be_sz_i   (ex_mem_sz),
    .be_off_i  (ex_addr[1:0]),
    .be_o      (be_new),
    .ld_sz_i   (sz_q),
    .ld_off_i  (addr_q[1:0]),
    .ld_sx_i   (sx_q),
    .rdata_i   (resp_rdata),
    .ld_data_o (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = REQ;
        stall   = 1'b1;
      end
      REQ: begin
        // A load keeps the pipe frozen through the handshake until its data returns.
        stall = !req_ready || !we_q;
        if (req_ready) state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        stall = !resp_valid;
        if (resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rstn) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      sx_q       <= 1'b0;
      sz_q       <= '0;
      rd_q       <= '0;
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
      ld_data_q  <= '0;
      exn_q      <= 1'b0;
      exn_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        be_q    <= be_new;
        we_q    <= ex_mem_w;
        sx_q    <= ex_mem_sx;
        sz_q    <= ex_mem_sz;
        rd_q    <= ex_rd;
      end
      ld_valid_q <= resp_take;
      if (resp_take) begin
        ld_rd_q   <= rd_q;
        ld_data_q <= ld_ext;
      end
      exn_q <= misalign;
      if (misalign) exn_addr_q <= ex_addr;
    end
  end

  assign req_valid    = (state_q == REQ);
  assign req_we       = we_q;
  assign req_addr     = {addr_q[31:2], 2'b00};
  assign req_wdata    = wdata_q;
  assign req_be       = be_q;
  assign ld_valid     = ld_valid_q;
  assign ld_rd        = ld_rd_q;
  assign ld_data      = ld_data_q;
  assign exn_misalign = exn_q;
  assign exn_addr     = exn_addr_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Self-checking bench for lsu_bus: directed scenarios plus randomized
// accesses checked against an arithmetic model of alignment, lanes and timing.
module tb_lsu_bus;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_mem_r, ex_mem_w, ex_mem_sx;
  logic [1:0]  ex_mem_sz;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall, ld_valid, exn_misalign;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data, exn_addr;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_bus dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_mem_sz(ex_mem_sz), .ex_mem_sx(ex_mem_sx), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .stall(stall), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .exn_misalign(exn_misalign), .exn_addr(exn_addr)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic over the access rules.
  function automatic logic ref_aligned(input int sz, input logic [31:0] addr);
    return (sz == 0) || (sz == 1 && addr % 2 == 0) || (sz == 2 && addr % 4 == 0);
  endfunction

  function automatic logic [3:0] ref_be(input int sz, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_ld(input int sz, input logic sx, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    longint v;
    v = longint'(rdata) / (longint'(1) << (8 * (addr % 4)));
    if (sz == 0) begin
      v = v % 256;
      if (sx && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (sx && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_r = 0; ex_mem_w = 0; ex_mem_sz = 0; ex_mem_sx = 0;
    ex_addr = 0; ex_wdata = 0; ex_rd = 0;
    req_ready = 0; resp_valid = 0; resp_rdata = 0;
  endtask

  // EX keeps presenting live accesses while busy; they must be ignored.
  task automatic garbage_ex();
    ex_valid = 1; ex_mem_r = 1'($urandom); ex_mem_w = 1'($urandom);
    ex_mem_sz = 2'($urandom); ex_mem_sx = 1'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
  endtask

  // One access from the accept cycle T through completion, checked every cycle.
  task automatic do_access(input string name, input bit w, input int sz, input bit sx,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input int rwait, input int dwait);
    logic al;
    logic [31:0] exp_addr;
    al = ref_aligned(sz, addr);
    exp_addr = addr - (addr % 4);
    $display("txn %s: %s sz=%0d sx=%0d addr=%h wdata=%h rd=%0d rwait=%0d dwait=%0d",
             name, w ? "store" : "load", sz, sx, addr, wdata, rd, rwait, dwait);
    @(negedge clk);
    ex_valid = 1; ex_mem_r = !w; ex_mem_w = w; ex_mem_sz = 2'(sz); ex_mem_sx = sx;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    req_ready = 1'($urandom); resp_valid = 1'($urandom); resp_rdata = $urandom;
    #1;
    n_checks++; if (stall !== al) begin n_err++; $display("FAIL %s accept stall: got %b exp %b", name, stall, al); end
    n_checks++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL %s accept req_valid: got %b exp 0", name, req_valid); end
    if (!al) begin
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (exn_misalign !== 1'b1) begin n_err++; $display("FAIL %s exn_misalign: got %b exp 1", name, exn_misalign); end
      n_checks++; if (exn_addr !== addr) begin n_err++; $display("FAIL %s exn_addr: got %h exp %h", name, exn_addr, addr); end
      n_checks++; if (req_valid !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0) begin
        n_err++; $display("FAIL %s misalign quiet: req_valid=%b stall=%b ld_valid=%b exp 0", name, req_valid, stall, ld_valid); end
      @(negedge clk); #1;
      n_checks++; if (exn_misalign !== 1'b0 || req_valid !== 1'b0) begin
        n_err++; $display("FAIL %s exn pulse end: exn=%b req_valid=%b exp 0", name, exn_misalign, req_valid); end
      return;
    end
    for (int k = 0; k <= rwait; k++) begin
      @(negedge clk); garbage_ex();
      req_ready = (k == rwait); resp_valid = 1'($urandom); resp_rdata = $urandom;
      #1;
      n_checks++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL %s req_valid[%0d]: got %b exp 1", name, k, req_valid); end
      n_checks++; if (req_we !== w) begin n_err++; $display("FAIL %s req_we[%0d]: got %b exp %b", name, k, req_we, w); end
      n_checks++; if (req_addr !== exp_addr) begin n_err++; $display("FAIL %s req_addr[%0d]: got %h exp %h", name, k, req_addr, exp_addr); end
      n_checks++; if (req_be !== ref_be(sz, addr)) begin n_err++; $display("FAIL %s req_be[%0d]: got %b exp %b", name, k, req_be, ref_be(sz, addr)); end
      n_checks++; if (req_wdata !== wdata) begin n_err++; $display("FAIL %s req_wdata[%0d]: got %h exp %h", name, k, req_wdata, wdata); end
      n_checks++; if (stall !== ((k < rwait) || !w)) begin
        n_err++; $display("FAIL %s req stall[%0d]: got %b exp %b", name, k, stall, (k < rwait) || !w); end
    end
    if (!w) begin
      for (int k = 0; k <= dwait; k++) begin
        @(negedge clk); garbage_ex();
        req_ready = 1'($urandom); resp_valid = (k == dwait);
        resp_rdata = (k == dwait) ? rdata : $urandom;
        #1;
        n_checks++; if (req_valid !== 1'b0 || ld_valid !== 1'b0) begin
          n_err++; $display("FAIL %s wait[%0d]: req_valid=%b ld_valid=%b exp 0", name, k, req_valid, ld_valid); end
        n_checks++; if (stall !== (k < dwait)) begin n_err++; $display("FAIL %s wait stall[%0d]: got %b exp %b", name, k, stall, k < dwait); end
      end
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (ld_valid !== 1'b1) begin n_err++; $display("FAIL %s ld_valid: got %b exp 1", name, ld_valid); end
      n_checks++; if (ld_rd !== rd) begin n_err++; $display("FAIL %s ld_rd: got %0d exp %0d", name, ld_rd, rd); end
      n_checks++; if (ld_data !== ref_ld(sz, sx, addr, rdata)) begin
        n_err++; $display("FAIL %s ld_data: got %h exp %h", name, ld_data, ref_ld(sz, sx, addr, rdata)); end
      n_checks++; if (exn_misalign !== 1'b0) begin n_err++; $display("FAIL %s exn with ld_valid: got %b exp 0", name, exn_misalign); end
      @(negedge clk); #1;
      n_checks++; if (ld_valid !== 1'b0) begin n_err++; $display("FAIL %s ld_valid pulse end: got %b exp 0", name, ld_valid); end
    end else begin
      @(negedge clk); idle_inputs(); #1;
      n_checks++; if (req_valid !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0) begin
        n_err++; $display("FAIL %s after store: req_valid=%b stall=%b ld_valid=%b exp 0", name, req_valid, stall, ld_valid); end
    end
  endtask

  task automatic test_reset();
    rstn = 0; idle_inputs();
    ex_valid = 1; ex_mem_r = 1; ex_mem_sz = 2; ex_addr = 32'h100; req_ready = 1; resp_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (stall !== 1'b0 || req_valid !== 1'b0 || ld_valid !== 1'b0 || exn_misalign !== 1'b0) begin
      n_err++; $display("FAIL reset ctrl: stall=%b req_valid=%b ld_valid=%b exn=%b exp 0", stall, req_valid, ld_valid, exn_misalign); end
    n_checks++; if (req_we !== 1'b0 || req_addr !== 32'h0 || req_wdata !== 32'h0 || req_be !== 4'h0) begin
      n_err++; $display("FAIL reset req: we=%b addr=%h wdata=%h be=%b exp 0", req_we, req_addr, req_wdata, req_be); end
    n_checks++; if (ld_rd !== 5'd0 || ld_data !== 32'h0 || exn_addr !== 32'h0) begin
      n_err++; $display("FAIL reset ld: rd=%0d data=%h exn_addr=%h exp 0", ld_rd, ld_data, exn_addr); end
    @(negedge clk); idle_inputs(); rstn = 1;
    $display("txn reset: released");
  endtask

  task automatic test_byte_load();
    do_access("byte_load_sx", 0, 0, 1, 32'h1003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0);
  endtask

  task automatic test_half_store_backpressure();
    do_access("half_store_bp", 1, 1, 0, 32'h2002, 32'hBEEF_BEEF, 5'd0, 32'h0, 3, 0);
  endtask

  task automatic test_misalign();
    do_access("word_misalign", 0, 2, 0, 32'h3001, 32'h0, 5'd3, 32'h0, 0, 0);
  endtask

  task automatic test_half_load();
    do_access("half_load_zx", 0, 1, 0, 32'h4002, 32'h0, 5'd19, 32'h9ABC_0000, 0, 0);
  endtask

  task automatic test_spurious_resp();
    @(negedge clk); idle_inputs(); resp_valid = 1; resp_rdata = 32'hDEAD_BEEF; #1;
    n_checks++; if (stall !== 1'b0 || req_valid !== 1'b0) begin
      n_err++; $display("FAIL spurious_resp: stall=%b req_valid=%b exp 0", stall, req_valid); end
    @(negedge clk); resp_valid = 0; #1;
    n_checks++; if (ld_valid !== 1'b0) begin n_err++; $display("FAIL spurious_resp ld_valid: got %b exp 0", ld_valid); end
    $display("txn spurious_resp: resp_valid in IDLE");
    do_access("sz3_reserved", 0, 3, 0, 32'h5000, 32'h0, 5'd4, 32'h0, 0, 0);
  endtask

  task automatic test_reset_in_wait();
    $display("txn reset_in_wait: word load to 6000, reset while waiting");
    @(negedge clk); idle_inputs();
    ex_valid = 1; ex_mem_r = 1; ex_mem_sz = 2; ex_addr = 32'h6000; ex_rd = 5'd9;
    @(negedge clk); idle_inputs(); req_ready = 1;
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_in_wait pre stall: got %b exp 1", stall); end
    rstn = 0; #1;
    n_checks++; if (req_valid !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0 || req_addr !== 32'h0 || req_be !== 4'h0) begin
      n_err++; $display("FAIL reset_in_wait outputs: req_valid=%b stall=%b ld_valid=%b addr=%h be=%b exp 0",
                        req_valid, stall, ld_valid, req_addr, req_be); end
    @(negedge clk); rstn = 1;
    @(negedge clk); resp_valid = 1; resp_rdata = 32'h1234_5678; #1;
    n_checks++; if (stall !== 1'b0 || req_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_in_wait resp: stall=%b req_valid=%b exp 0", stall, req_valid); end
    @(negedge clk); resp_valid = 0; #1;
    n_checks++; if (ld_valid !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_in_wait after: ld_valid=%b stall=%b exp 0", ld_valid, stall); end
    do_access("post_reset_load", 0, 2, 0, 32'h6004, 32'h0, 5'd10, 32'hCAFE_F00D, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit w;
      int sz;
      w = 1'($urandom);
      sz = int'($urandom_range(0, 3));
      do_access($sformatf("rand%0d", i), w, sz, 1'($urandom), $urandom, $urandom,
                5'($urandom), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_half_store_backpressure();
    test_misalign();
    test_half_load();
    test_spurious_resp();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
